// File: rtl/tt_bist_pkg.sv
// ============================================================================
// Module : tt_bist_pkg
// Brief  : Shared types and step functions for the tt_bist harness.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tt_bist_pkg;

  localparam int c_MAXW = 64;

  typedef enum logic [1:0] {
    MODE_REPLAY = 2'd0,
    MODE_LFSR   = 2'd1,
    MODE_HOLD   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_APPLY  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Galois shift of a w-bit register held in the low bits of a c_MAXW vector.
  function automatic logic [c_MAXW-1:0] misr_step(input logic [c_MAXW-1:0] cur,
                                                  input logic [c_MAXW-1:0] din,
                                                  input logic [c_MAXW-1:0] poly,
                                                  input int w);
    logic [c_MAXW-1:0] mask;
    logic              msb;
    mask = (w >= c_MAXW) ? '1 : ((c_MAXW'(1) << w) - c_MAXW'(1));
    msb  = |(cur & (mask ^ (mask >> 1)));
    return ((cur << 1) ^ din ^ (msb ? poly : {c_MAXW{1'b0}})) & mask;
  endfunction

  function automatic logic [c_MAXW-1:0] lfsr_step(input logic [c_MAXW-1:0] cur,
                                                  input logic [c_MAXW-1:0] poly,
                                                  input int w);
    return misr_step(cur, {c_MAXW{1'b0}}, poly, w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tt_bist_misr.sv
// ============================================================================
// Module : tt_bist_misr
// Brief  : Galois MISR; with i_din tied to zero it runs as an autonomous LFSR.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tt_bist_misr
  import tt_bist_pkg::*;
#(
  parameter int              IO_W      = 8,
  parameter logic [IO_W-1:0] MISR_POLY = 'h1D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_ld,
  input  logic [IO_W-1:0] i_ld_val,
  input  logic            i_en,
  input  logic [IO_W-1:0] i_din,
  output logic [IO_W-1:0] o_q
);

  logic [IO_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_ld)  r_q <= i_ld_val;
    else if (i_en)  r_q <= IO_W'(misr_step(c_MAXW'(r_q), c_MAXW'(i_din), c_MAXW'(MISR_POLY), IO_W));
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/tt_bist_harness.sv
// ============================================================================
// Module : tt_bist_harness
// Brief  : Stimulus/capture harness: drives a tt_um_* design, counts mismatches, builds a MISR signature.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tt_bist_harness
  import tt_bist_pkg::*;
#(
  parameter int              IO_W      = 8,
  parameter int              DEPTH     = 16,
  parameter int              SETTLE    = 2,
  parameter int              RST_CYC   = 4,
  parameter logic [IO_W-1:0] MISR_POLY = 'h1D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic [$clog2(DEPTH):0]   run_len,
  input  logic [IO_W-1:0]          seed,
  input  logic                     vec_we,
  input  logic [$clog2(DEPTH)-1:0] vec_addr,
  input  logic [3*IO_W-1:0]        vec_data,
  input  logic [IO_W-1:0]          dut_uo_out,
  input  logic [IO_W-1:0]          dut_uio_out,
  input  logic [IO_W-1:0]          dut_uio_oe,
  output logic [IO_W-1:0]          dut_ui_in,
  output logic [IO_W-1:0]          dut_uio_in,
  output logic                     dut_rst_n,
  output logic                     dut_ena,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               fail_count,
  output logic [IO_W-1:0]          signature
);

  localparam int              c_AW        = $clog2(DEPTH);
  localparam int              c_CMAX      = (RST_CYC > SETTLE) ? RST_CYC : SETTLE;
  localparam int              c_CW        = $clog2(c_CMAX + 1);
  localparam logic [c_CW-1:0] c_RST_LAST  = c_CW'(RST_CYC - 1);
  localparam logic [c_CW-1:0] c_WAIT_LAST = c_CW'((SETTLE > 1) ? SETTLE - 2 : 0);
  localparam logic [c_AW:0]   c_DEPTH     = (c_AW + 1)'(DEPTH);

  logic [3*IO_W-1:0] r_mem [DEPTH];
  state_e            r_state;
  mode_e             r_mode;
  logic [c_AW:0]     r_len;
  logic [c_AW:0]     r_idx;
  logic [c_CW-1:0]   r_cnt;
  logic [IO_W-1:0]   r_exp;

  logic [c_AW-1:0]   w_rd_addr;
  logic [3*IO_W-1:0] w_vec;
  logic [IO_W-1:0]   w_lfsr;
  logic [IO_W-1:0]   w_seed;
  logic [IO_W-1:0]   w_obs_uio;
  logic              w_go;
  logic              w_lfsr_en;
  logic              w_sample;

  assign w_go      = start && !abort && (r_state == ST_IDLE);
  assign w_lfsr_en = !abort && (r_state == ST_APPLY) && (r_mode == MODE_LFSR);
  assign w_sample  = !abort && (r_state == ST_SAMPLE);
  assign w_seed    = (seed == '0) ? IO_W'(1) : seed;
  assign w_rd_addr = (r_mode == MODE_HOLD) ? '0 : r_idx[c_AW-1:0];
  assign w_vec     = r_mem[w_rd_addr];
  // Bidir pins the DUT is not driving read back the harness's own stimulus.
  assign w_obs_uio = (dut_uio_out & dut_uio_oe) | (dut_uio_in & ~dut_uio_oe);

  always_ff @(posedge clk) begin
    if (vec_we && (r_state == ST_IDLE)) r_mem[vec_addr] <= vec_data;
  end

  tt_bist_misr #(.IO_W(IO_W), .MISR_POLY(MISR_POLY)) u_misr (
    .clk(clk), .rst_n(rst_n), .i_clr(w_go), .i_ld(1'b0), .i_ld_val('0),
    .i_en(w_sample), .i_din(dut_uo_out ^ w_obs_uio), .o_q(signature)
  );

  tt_bist_misr #(.IO_W(IO_W), .MISR_POLY(MISR_POLY)) u_lfsr (
    .clk(clk), .rst_n(rst_n), .i_clr(1'b0), .i_ld(w_go), .i_ld_val(w_seed),
    .i_en(w_lfsr_en), .i_din('0), .o_q(w_lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_REPLAY;
      r_len      <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_exp      <= '0;
      dut_ui_in  <= '0;
      dut_uio_in <= '0;
      dut_rst_n  <= 1'b0;
      dut_ena    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail_count <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        r_state   <= ST_IDLE;
        busy      <= 1'b0;
        dut_ena   <= 1'b0;
        dut_rst_n <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (start) begin
            r_state    <= ST_RESET;
            busy       <= 1'b1;
            dut_rst_n  <= 1'b0;
            dut_ena    <= 1'b1;
            fail_count <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_len      <= (run_len > c_DEPTH) ? c_DEPTH : run_len;
            r_mode     <= (mode == MODE_LFSR) ? MODE_LFSR :
                          (mode == MODE_HOLD) ? MODE_HOLD : MODE_REPLAY;
          end
          ST_RESET: begin
            if (r_cnt == c_RST_LAST) begin
              dut_rst_n <= 1'b1;
              r_cnt     <= '0;
              if (r_len == '0) begin
                r_state <= ST_DONE;
                done    <= 1'b1;
              end else begin
                r_state <= ST_APPLY;
              end
            end else begin
              r_cnt <= r_cnt + c_CW'(1);
            end
          end
          ST_APPLY: begin
            if (r_mode == MODE_LFSR) begin
              dut_ui_in  <= w_lfsr;
              dut_uio_in <= ~w_lfsr;
            end else begin
              dut_ui_in  <= w_vec[IO_W-1:0];
              dut_uio_in <= w_vec[2*IO_W-1:IO_W];
              r_exp      <= w_vec[3*IO_W-1:2*IO_W];
            end
            r_cnt   <= '0;
            r_state <= (SETTLE > 1) ? ST_WAIT : ST_SAMPLE;
          end
          ST_WAIT: begin
            if (r_cnt == c_WAIT_LAST) r_state <= ST_SAMPLE;
            else                      r_cnt   <= r_cnt + c_CW'(1);
          end
          ST_SAMPLE: begin
            if ((r_mode != MODE_LFSR) && (dut_uo_out != r_exp) && (fail_count != 8'hFF))
              fail_count <= fail_count + 8'd1;
            if ((r_idx + (c_AW + 1)'(1)) < r_len) begin
              r_idx   <= r_idx + (c_AW + 1)'(1);
              r_state <= ST_APPLY;
            end else begin
              r_state <= ST_DONE;
              done    <= 1'b1;
            end
          end
          ST_DONE: begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tt_bist_harness.sv
// ============================================================================
// Module : tb_tt_bist_harness
// Brief  : Self-checking bench for tt_bist_harness against a vector-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tt_bist_harness;

  localparam int RST_CYC = 4;
  localparam int SETTLE  = 2;
  localparam int DEPTH   = 16;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, vec_we, big_start;
  logic [1:0]  mode;
  logic [4:0]  run_len;
  logic [9:0]  big_run_len;
  logic [7:0]  seed, uo_xor, oe;
  logic [3:0]  vec_addr;
  logic [23:0] vec_data;

  logic [7:0] d_ui, d_uio, d_uo, d_uio_out, fail_count, signature;
  logic       dut_rst_n, dut_ena, busy, done;
  logic [7:0] b_ui, b_uio, b_uo, b_uio_out, b_fail, b_sig;
  logic       b_rst_n, b_ena, b_busy, b_done;

  logic [7:0] m_ui [16];
  logic [7:0] m_uio[16];
  logic [7:0] m_exp[16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural user design: echo ui on uo (optionally corrupted), bidir out = ui ^ C3.
  assign d_uo      = d_ui ^ uo_xor;
  assign d_uio_out = d_ui ^ 8'hC3;
  assign b_uo      = b_ui ^ uo_xor;
  assign b_uio_out = b_ui ^ 8'hC3;

  tt_bist_harness #(.IO_W(8), .DEPTH(DEPTH), .SETTLE(SETTLE), .RST_CYC(RST_CYC), .MISR_POLY(8'h1D)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .run_len(run_len),
    .seed(seed), .vec_we(vec_we), .vec_addr(vec_addr), .vec_data(vec_data),
    .dut_uo_out(d_uo), .dut_uio_out(d_uio_out), .dut_uio_oe(oe),
    .dut_ui_in(d_ui), .dut_uio_in(d_uio), .dut_rst_n(dut_rst_n), .dut_ena(dut_ena),
    .busy(busy), .done(done), .fail_count(fail_count), .signature(signature)
  );

  tt_bist_harness #(.IO_W(8), .DEPTH(512), .SETTLE(SETTLE), .RST_CYC(RST_CYC), .MISR_POLY(8'h1D)) u_big (
    .clk(clk), .rst_n(rst_n), .start(big_start), .abort(abort), .mode(mode), .run_len(big_run_len),
    .seed(seed), .vec_we(vec_we), .vec_addr({5'd0, vec_addr}), .vec_data(vec_data),
    .dut_uo_out(b_uo), .dut_uio_out(b_uio_out), .dut_uio_oe(oe),
    .dut_ui_in(b_ui), .dut_uio_in(b_uio), .dut_rst_n(b_rst_n), .dut_ena(b_ena),
    .busy(b_busy), .done(b_done), .fail_count(b_fail), .signature(b_sig)
  );

  function automatic logic [7:0] gal(input logic [7:0] s);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
  endfunction

  // Walks the run vector by vector: what is driven, what the design answers, what the MISR folds.
  task automatic model_run(input int md, input int len, input int depth, input logic [7:0] sd,
                           output logic [7:0] sig, output int fails, output logic [7:0] first_ui,
                           output logic [7:0] last_ui, output int n);
    logic [7:0] l, ui, uio, ex, uo, uo_io, obs;
    int k;
    n = (len > depth) ? depth : len;
    l = (sd == 8'd0) ? 8'd1 : sd;
    sig = 8'd0; fails = 0; first_ui = 8'd0; last_ui = 8'd0;
    for (int i = 0; i < n; i++) begin
      if (md == 1) begin
        ui = l; uio = ~l; ex = 8'd0; l = gal(l);
      end else begin
        k = (md == 2) ? 0 : i;
        ui = m_ui[k]; uio = m_uio[k]; ex = m_exp[k];
      end
      uo    = ui ^ uo_xor;
      uo_io = ui ^ 8'hC3;
      obs   = (uo_io & oe) | (uio & ~oe);
      sig   = gal(sig) ^ uo ^ obs;
      if (md != 1 && uo != ex) fails++;
      if (i == 0) first_ui = ui;
      last_ui = ui;
    end
    if (fails > 255) fails = 255;
  endtask

  task automatic write_vec(input int a, input logic [7:0] ui, input logic [7:0] uio, input logic [7:0] ex);
    vec_we = 1'b1; vec_addr = 4'(a); vec_data = {ex, uio, ui};
    m_ui[a] = ui; m_uio[a] = uio; m_exp[a] = ex;
    @(posedge clk); #1;
    vec_we = 1'b0;
  endtask

  task automatic load_random(input int cnt);
    logic [7:0] u;
    for (int i = 0; i < cnt; i++) begin
      u = 8'($urandom);
      write_vec(i, u, 8'($urandom), u);
    end
  endtask

  // One full run on the small instance; poke_at>0 fires start+vec_we while busy.
  task automatic run_check(input string name, input int md, input int len, input logic [7:0] sd, input int poke_at);
    logic [7:0] e_sig, e_first, e_last, s_sig;
    int e_fail, n, e_lat, got_lat;
    model_run(md, len, DEPTH, sd, e_sig, e_fail, e_first, e_last, n);
    e_lat = RST_CYC + n * (SETTLE + 1);
    mode = 2'(md); run_len = 5'(len); seed = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || dut_rst_n !== 1'b0 || dut_ena !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_start: busy/rst_n/ena=%b%b%b required 101", name, busy, dut_rst_n, dut_ena);
    end
    got_lat = -1;
    for (int k = 1; k <= e_lat + 20 && got_lat < 0; k++) begin
      if (k == poke_at) begin
        start = 1'b1; vec_we = 1'b1; vec_addr = 4'd1; vec_data = 24'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0; vec_we = 1'b0;
      if (n > 0 && k == RST_CYC + 1) begin
        n_checks++;
        if (d_ui !== e_first) begin
          n_fail++;
          $display("FAIL %s_first_ui: got %h required %h", name, d_ui, e_first);
        end
      end
      if (done === 1'b1) got_lat = k;
    end
    n_checks++;
    if (got_lat != e_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d required %0d (-1 = timeout)", name, got_lat, e_lat);
    end
    n_checks++;
    if (fail_count !== 8'(e_fail)) begin
      n_fail++;
      $display("FAIL %s_fail_count: got %0d required %0d", name, fail_count, e_fail);
    end
    n_checks++;
    if (signature !== e_sig) begin
      n_fail++;
      $display("FAIL %s_signature: got %h required %h", name, signature, e_sig);
    end
    n_checks++;
    if (busy !== 1'b1 || dut_rst_n !== 1'b1 || dut_ena !== 1'b1 || (n > 0 && d_ui !== e_last)) begin
      n_fail++;
      $display("FAIL %s_at_done: busy=%b rst_n=%b ena=%b ui=%h required 1 1 1 ui=%h", name, busy, dut_rst_n, dut_ena, d_ui, e_last);
    end
    s_sig = signature;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || signature !== s_sig) begin
      n_fail++;
      $display("FAIL %s_after_done: busy=%b done=%b sig=%h required 0 0 %h", name, busy, done, signature, s_sig);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({d_ui, d_uio, fail_count, signature} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_buses: ui=%h uio=%h fc=%h sig=%h required all 0", d_ui, d_uio, fail_count, signature);
    end
    n_checks++;
    if ({dut_rst_n, dut_ena, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: rst_n/ena/busy/done=%b required 0000", {dut_rst_n, dut_ena, busy, done});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_replay_loopback();
    uo_xor = 8'h00; oe = 8'hFF;
    load_random(4);
    run_check("replay4", 0, 4, 8'h00, 0);
  endtask

  task automatic test_corrupt();
    write_vec(2, m_ui[2], m_uio[2], ~m_ui[2]);
    run_check("corrupt", 0, 4, 8'h00, 0);
    run_check("mode3_replay", 3, 4, 8'h00, 0);
  endtask

  task automatic test_lfsr();
    run_check("lfsr_seed0", 1, 8, 8'h00, 0);
    run_check("lfsr_rand", 1, 11, 8'($urandom_range(1, 255)), 0);
  endtask

  task automatic test_uio_oe();
    oe = 8'hF0;
    load_random(6);
    run_check("uio_oe", 0, 6, 8'h00, 0);
    run_check("hold", 2, 5, 8'h00, 0);
    oe = 8'hFF;
  endtask

  task automatic test_back_to_back();
    load_random(4);
    run_check("busy_poke", 0, 4, 8'h00, 8);
    run_check("after_poke", 0, 4, 8'h00, 0);
  endtask

  task automatic test_abort();
    int seen;
    mode = 2'd0; run_len = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (RST_CYC + 1) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if ({busy, dut_rst_n, dut_ena, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_wait: busy/rst_n/ena/done=%b required 0000", {busy, dut_rst_n, dut_ena, done});
    end
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d cycles with done/busy, required 0", seen);
    end
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, dut_ena, dut_rst_n} !== 3'b000) begin
      n_fail++;
      $display("FAIL start_abort_same: busy/ena/rst_n=%b required 000", {busy, dut_ena, dut_rst_n});
    end
  endtask

  task automatic test_run_len_edges();
    load_random(16);
    run_check("len0", 0, 0, 8'h00, 0);
    run_check("len_clamp", 0, DEPTH + 1, 8'h00, 0);
  endtask

  task automatic test_saturate();
    logic [7:0] e_sig, e_first, e_last;
    int e_fail, n, e_lat, got_lat;
    write_vec(0, 8'h3C, 8'h99, 8'hC3);
    model_run(2, 300, 512, 8'h00, e_sig, e_fail, e_first, e_last, n);
    e_lat = RST_CYC + n * (SETTLE + 1);
    mode = 2'd2; big_run_len = 10'd300; big_start = 1'b1;
    @(posedge clk); #1;
    big_start = 1'b0;
    got_lat = -1;
    for (int k = 1; k <= e_lat + 50 && got_lat < 0; k++) begin
      @(posedge clk); #1;
      if (b_done === 1'b1) got_lat = k;
    end
    n_checks++;
    if (got_lat != e_lat) begin
      n_fail++;
      $display("FAIL sat_latency: got %0d required %0d (-1 = timeout)", got_lat, e_lat);
    end
    n_checks++;
    if (b_fail !== 8'(e_fail)) begin
      n_fail++;
      $display("FAIL sat_fail_count: got %0d required %0d", b_fail, e_fail);
    end
    n_checks++;
    if (b_sig !== e_sig) begin
      n_fail++;
      $display("FAIL sat_signature: got %h required %h", b_sig, e_sig);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    load_random(4);
    mode = 2'd0; run_len = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({d_ui, d_uio, fail_count, signature, dut_rst_n, dut_ena, busy, done} !== 36'd0) begin
      n_fail++;
      $display("FAIL async_reset: ui=%h uio=%h fc=%h sig=%h ctrl=%b required all 0",
               d_ui, d_uio, fail_count, signature, {dut_rst_n, dut_ena, busy, done});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL async_reset_no_done: %0d cycles with done/busy, required 0", seen);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; big_start = 1'b0; abort = 1'b0; vec_we = 1'b0;
    mode = 2'd0; run_len = 5'd0; big_run_len = 10'd0; seed = 8'd0;
    vec_addr = 4'd0; vec_data = 24'd0; uo_xor = 8'd0; oe = 8'hFF;
    test_reset();
    test_replay_loopback();
    test_corrupt();
    test_lfsr();
    test_uio_oe();
    test_back_to_back();
    test_abort();
    test_run_len_edges();
    test_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
